// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC and issues one instruction-memory read at a time.
// Returned words go to decode with their PC. Control-flow redirects replace the
// sequential PC, and any fetch still in flight is squashed.
module ifu #(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic                  fetch_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   tgt_q, tgt_d;
    logic                  pend_q, pend_d;
    logic                  drop_q, drop_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [PC_WIDTH-1:0]   inst_pc_q, inst_pc_d;
    logic                  fault_q, fault_d;
    logic                  misaligned;

    // A redirect target that is not word aligned is fatal for the fetch stream.
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // All outputs come from registered state, so nothing combinational reaches them from inputs.
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == OUT);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_fault    = fault_q;

    // State and datapath registers; reset puts the unit in IDLE at RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            tgt_q     <= '0;
            pend_q    <= 1'b0;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state logic: while a request is held, redirects are parked in tgt/pend and the returning data is dropped.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;

        if (state_q != FAULT && misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        pend_d = 1'b1;
                        tgt_d  = redirect_pc;
                    end
                    if (imem_req_ready) begin
                        state_d = WAIT;
                        drop_d  = pend_q | redirect_valid;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q || pend_q || redirect_valid) begin
                            pc_d    = redirect_valid ? redirect_pc : tgt_q;
                            pend_d  = 1'b0;
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            inst_d    = imem_resp_data;
                            inst_pc_d = pc_q;
                            pc_d      = pc_q + PC_WIDTH'(4);
                            state_d   = OUT;
                        end
                    end else if (redirect_valid) begin
                        pend_d = 1'b1;
                        tgt_d  = redirect_pc;
                        drop_d = 1'b1;
                    end
                end
                OUT: begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = REQ;
                    end else if (inst_ready) begin
                        state_d = REQ;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
